// File: rtl/bfsk_frame_scheduler_if.sv
// Frame handshake and tone-control bundle between an upstream frame source and the BFSK scheduler.
// The master drives payload/valid; the slave (scheduler) drives ready and the modulator controls.
interface bfsk_frame_scheduler_if #(
    parameter int LDATA = 8
);
    logic [LDATA-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             tone_sel;
    logic             tone_en;
    logic             bit_strobe;
    logic             frame_done;
    logic             busy;

    modport master (
        output data_in, data_valid,
        input  data_ready, tone_sel, tone_en, bit_strobe, frame_done, busy
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, tone_sel, tone_en, bit_strobe, frame_done, busy
    );
endinterface

// File: rtl/bfsk_frame_scheduler.sv
// BFSK frame scheduler: serialises an LDATA-bit frame LSB first into NB-cycle tone periods, then GAP_BITS silent periods.
// Latency: first bit period starts the cycle after acceptance; BFSK_PREAMBLE_EN adds an 8-bit 0xAA preamble before the data.
// Backpressure: data_ready only in IDLE; data_valid seen while busy is dropped, never queued.
module bfsk_frame_scheduler #(
    parameter int LDATA    = 8,
    parameter int NB       = 256,
    parameter int GAP_BITS = 2
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    bfsk_frame_scheduler_if.slave  bus
);

`ifdef BFSK_PREAMBLE_EN
    localparam int PRE_LAST = 7;
`else
    localparam int PRE_LAST = 0;
`endif
    localparam int GAP_LAST  = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
    localparam int IDX_MAX_A = (LDATA - 1 > GAP_LAST) ? LDATA - 1 : GAP_LAST;
    localparam int IDX_MAX   = (IDX_MAX_A > PRE_LAST) ? IDX_MAX_A : PRE_LAST;
    localparam int CNT_W     = $clog2(NB - 1) + 1;
    localparam int IDX_W     = $clog2(IDX_MAX) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(NB - 1);
    localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(LDATA - 1);
    localparam logic [IDX_W-1:0] IDX_GAP_LAST  = IDX_W'(GAP_LAST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef BFSK_PREAMBLE_EN
        S_PRE  = 2'd1,
`endif
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LDATA-1:0]   sh_q, sh_d;
    logic [LDATA-1:0]   sh_next;
    logic               cnt_wrap;
    logic               tone_sel_q, tone_sel_d;
    logic               tone_en_q, tone_en_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

`ifdef BFSK_PREAMBLE_EN
    localparam logic [IDX_W-1:0] IDX_PRE_LAST = IDX_W'(PRE_LAST);
    localparam logic [7:0]       PRE_PAT      = 8'hAA;
    logic [2:0] pre_nxt;
    assign pre_nxt = idx_q[2:0] + 3'd1;
`endif

    assign cnt_wrap = (cnt_q == CNT_LAST);
    assign sh_next  = sh_q >> 1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sh_d       = sh_q;
        tone_sel_d = 1'b0;
        tone_en_d  = 1'b0;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.data_valid) begin
                    sh_d      = bus.data_in;
                    cnt_d     = '0;
                    idx_d     = '0;
                    tone_en_d = 1'b1;
                    strobe_d  = 1'b1;
`ifdef BFSK_PREAMBLE_EN
                    state_d    = S_PRE;
                    tone_sel_d = PRE_PAT[0];
`else
                    state_d    = S_DATA;
                    tone_sel_d = bus.data_in[0];
`endif
                end
            end
`ifdef BFSK_PREAMBLE_EN
            S_PRE: begin
                tone_en_d  = 1'b1;
                tone_sel_d = tone_sel_q;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_wrap) begin
                    cnt_d    = '0;
                    strobe_d = 1'b1;
                    if (idx_q == IDX_PRE_LAST) begin
                        idx_d      = '0;
                        state_d    = S_DATA;
                        tone_sel_d = sh_q[0];
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        tone_sel_d = PRE_PAT[pre_nxt];
                    end
                end
            end
`endif
            S_DATA: begin
                tone_en_d  = 1'b1;
                tone_sel_d = tone_sel_q;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_wrap) begin
                    cnt_d = '0;
                    if (idx_q == IDX_DATA_LAST) begin
                        // Frame ends: carrier drops on the same cycle frame_done pulses.
                        idx_d      = '0;
                        done_d     = 1'b1;
                        tone_en_d  = 1'b0;
                        tone_sel_d = 1'b0;
                        state_d    = (GAP_BITS == 0) ? S_IDLE : S_GAP;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        sh_d       = sh_next;
                        tone_sel_d = sh_next[0];
                        strobe_d   = 1'b1;
                    end
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_wrap) begin
                    cnt_d = '0;
                    if (idx_q == IDX_GAP_LAST) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_q       <= '0;
            tone_sel_q <= 1'b0;
            tone_en_q  <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            tone_sel_q <= tone_sel_d;
            tone_en_q  <= tone_en_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Ready is the only combinational output so acceptance never costs an extra idle cycle.
    assign bus.data_ready = (state_q == S_IDLE) && !reset;
    assign bus.tone_sel   = tone_sel_q;
    assign bus.tone_en    = tone_en_q;
    assign bus.bit_strobe = strobe_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bfsk_frame_scheduler.sv
// Bench for bfsk_frame_scheduler: scoreboarded tone stream on a GAP_BITS=2 instance plus directed GAP_BITS=0 checks.
module tb_bfsk_frame_scheduler;
    localparam int NB    = 4;
    localparam int LDATA = 8;
`ifdef BFSK_PREAMBLE_EN
    localparam int PRE_BITS = 8;
`else
    localparam int PRE_BITS = 0;
`endif
    localparam int FRAME_BITS = PRE_BITS + LDATA;
    localparam int FRAME_CYC  = FRAME_BITS * NB;
    localparam int GAP_CYC    = 2 * NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bfsk_frame_scheduler_if #(.LDATA(LDATA)) bus_a ();
    bfsk_frame_scheduler_if #(.LDATA(LDATA)) bus_b ();

    bfsk_frame_scheduler #(.LDATA(LDATA), .NB(NB), .GAP_BITS(2)) dut_a (
        .CLOCK_50 (clk),
        .reset    (rst_a),
        .bus      (bus_a)
    );

    bfsk_frame_scheduler #(.LDATA(LDATA), .NB(NB), .GAP_BITS(0)) dut_b (
        .CLOCK_50 (clk),
        .reset    (rst_b),
        .bus      (bus_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: bit values and frame_done cycles pushed on acceptance, popped on strobe/done.
    bit         exp_bits[$];
    int         exp_done[$];
    bit         cur_bit = 1'b0;
    int         run_len = 0;
    int         strb_cnt = 0;
    logic [7:0] acc_d;

    always @(negedge clk) begin
        if (rst_a) begin
            exp_bits.delete();
            exp_done.delete();
            run_len  = 0;
            strb_cnt = 0;
        end else begin
            if (bus_a.data_valid && bus_a.data_ready) begin
                acc_d = bus_a.data_in;
                for (int i = 0; i < PRE_BITS; i++) exp_bits.push_back(bit'(i % 2));
                for (int i = 0; i < LDATA; i++) exp_bits.push_back(acc_d[i]);
                exp_done.push_back(cyc + 1 + FRAME_CYC);
            end
            if (bus_a.bit_strobe) begin
                if (run_len != 0) chk("bit_len", run_len, NB);
                chk("strobe_expected", exp_bits.size() > 0, 1);
                if (exp_bits.size() > 0) cur_bit = exp_bits.pop_front();
                run_len = 0;
                strb_cnt++;
            end
            if (bus_a.tone_en) begin
                run_len++;
                chk("tone_sel", bus_a.tone_sel, cur_bit);
            end else begin
                chk("quiet_sel", bus_a.tone_sel, 0);
                chk("quiet_strobe", bus_a.bit_strobe, 0);
            end
            if (bus_a.frame_done) begin
                chk("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) chk("done_cycle", cyc, exp_done.pop_front());
                chk("last_bit_len", run_len, NB);
                chk("strobe_count", strb_cnt, FRAME_BITS);
                run_len  = 0;
                strb_cnt = 0;
            end
        end
    end

    task automatic at_cyc(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cyc >= n) break;
        end
        chk("sched_cycle", cyc, n);
    endtask

    // Drives a frame on bus_a and returns the acceptance cycle.
    task automatic send_a(input logic [7:0] d, output int t);
        bit got;
        got = 1'b0;
        t   = -1;
        @(posedge clk); #1;
        bus_a.data_in    = d;
        bus_a.data_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus_a.data_ready) begin
                got = 1'b1;
                t   = cyc;
                break;
            end
        end
        chk("accept_timeout", got, 1);
        @(posedge clk); #1;
        bus_a.data_valid = 1'b0;
        bus_a.data_in    = 8'($urandom);
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!bus_a.busy && bus_a.data_ready) break;
        end
        chk("idle_timeout", bus_a.busy, 0);
    endtask

    logic [7:0] pats [4] = '{8'h00, 8'hFF, 8'h5C, 8'h96};
    bit         bbits[FRAME_BITS];
    logic [7:0] bdat;
    int         t, t1, t2;
    bit         got2;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.data_valid = 1'b0;
        bus_a.data_in    = '0;
        bus_b.data_valid = 1'b0;
        bus_b.data_in    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tone_en", bus_a.tone_en, 0);
        chk("rst_tone_sel", bus_a.tone_sel, 0);
        chk("rst_strobe", bus_a.bit_strobe, 0);
        chk("rst_done", bus_a.frame_done, 0);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_ready", bus_a.data_ready, 0);
        chk("rst_ready_b", bus_b.data_ready, 0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus_a.data_ready, 1);

        // Single 0xAA frame: timing of strobe, done and return to IDLE.
        send_a(8'hAA, t);
        at_cyc(t + 1);
        chk("first_strobe", bus_a.bit_strobe, 1);
        chk("first_en", bus_a.tone_en, 1);
        chk("first_busy", bus_a.busy, 1);
        chk("first_ready", bus_a.data_ready, 0);
        at_cyc(t + FRAME_CYC);
        chk("last_data_en", bus_a.tone_en, 1);
        at_cyc(t + 1 + FRAME_CYC);
        chk("done_pulse", bus_a.frame_done, 1);
        chk("gap_en", bus_a.tone_en, 0);
        at_cyc(t + 2 + FRAME_CYC);
        chk("done_one_cycle", bus_a.frame_done, 0);
        at_cyc(t + FRAME_CYC + GAP_CYC);
        chk("gap_busy", bus_a.busy, 1);
        chk("gap_ready", bus_a.data_ready, 0);
        at_cyc(t + 1 + FRAME_CYC + GAP_CYC);
        chk("idle_busy", bus_a.busy, 0);
        chk("idle_ready", bus_a.data_ready, 1);

        foreach (pats[i]) begin
            send_a(pats[i], t);
            wait_idle_a();
        end
        send_a(8'($urandom), t);
        wait_idle_a();

        // data_valid held high: second frame waits for IDLE, first frame keeps its payload.
        @(posedge clk); #1;
        bus_a.data_in    = 8'h01;
        bus_a.data_valid = 1'b1;
        t1 = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus_a.data_ready) begin t1 = cyc; break; end
        end
        @(posedge clk); #1;
        bus_a.data_in = 8'h80;
        t2   = -1;
        got2 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus_a.data_ready) begin t2 = cyc; got2 = 1'b1; break; end
        end
        chk("hold_second_seen", got2, 1);
        chk("hold_second_cycle", t2, t1 + 1 + FRAME_CYC + GAP_CYC);
        @(posedge clk); #1;
        bus_a.data_valid = 1'b0;
        wait_idle_a();

        // Reset during the 10th DATA cycle aborts the frame.
        send_a(8'hC3, t);
        at_cyc(t + PRE_BITS * NB + 10);
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("abort_en", bus_a.tone_en, 0);
        chk("abort_busy", bus_a.busy, 0);
        chk("abort_done", bus_a.frame_done, 0);
        chk("abort_ready", bus_a.data_ready, 1);
        repeat (FRAME_CYC + GAP_CYC) @(negedge clk);

        // Reset beats a simultaneous acceptance.
        @(posedge clk); #1;
        rst_a = 1'b1;
        bus_a.data_valid = 1'b1;
        bus_a.data_in    = 8'h33;
        @(negedge clk);
        chk("rst_prio_ready", bus_a.data_ready, 0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        bus_a.data_valid = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", bus_a.busy, 0);
        chk("rst_prio_en", bus_a.tone_en, 0);

        // GAP_BITS=0: frame_done lands on the first IDLE cycle, back-to-back accept.
        bdat = 8'h0F;
        for (int i = 0; i < PRE_BITS; i++) bbits[i] = bit'(i % 2);
        for (int i = 0; i < LDATA; i++) bbits[PRE_BITS + i] = bdat[i];
        @(posedge clk); #1;
        bus_b.data_in    = bdat;
        bus_b.data_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus_b.data_ready) begin t = cyc; break; end
        end
        for (int k = 0; k < FRAME_CYC; k++) begin
            at_cyc(t + 1 + k);
            chk("b_tone_sel", bus_b.tone_sel, bbits[k / NB]);
            chk("b_tone_en", bus_b.tone_en, 1);
        end
        at_cyc(t + 1 + FRAME_CYC);
        chk("b_done", bus_b.frame_done, 1);
        chk("b_done_ready", bus_b.data_ready, 1);
        chk("b_done_busy", bus_b.busy, 0);
        chk("b_done_en", bus_b.tone_en, 0);
        at_cyc(t + 2 + FRAME_CYC);
        chk("b_restart_en", bus_b.tone_en, 1);
        chk("b_restart_strobe", bus_b.bit_strobe, 1);
        chk("b_restart_busy", bus_b.busy, 1);
        @(posedge clk); #1;
        bus_b.data_valid = 1'b0;

        repeat (4) @(negedge clk);
        chk("done_leftover", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bfsk_frame_scheduler.md
BFSK_FRAME_SCHEDULER -- requirements
Module: bfsk_frame_scheduler

Interface
REQ-001 Parameter LDATA, default 8: data bits per frame.
REQ-002 Parameter NB, default 256: clock cycles per bit period; legal range 2..65535.
REQ-003 Parameter GAP_BITS, default 2: silent bit periods after each frame; legal range 0..15.
REQ-004 CLOCK_50  input  1  sole clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_in  input  LDATA  frame payload, sampled on acceptance.
REQ-007 data_valid  input  1  upstream has a frame to send.
REQ-008 data_ready  output  1  scheduler can accept a frame.
REQ-009 tone_sel  output  1  tone select for the modulator datapath: 0 = signal1 (space), 1 = signal2 (mark).
REQ-010 tone_en  output  1  carrier enable; 0 = datapath drives idle level 16'd32768.
REQ-011 bit_strobe  output  1  one-cycle pulse on the first cycle of every transmitted bit period.
REQ-012 frame_done  output  1  one-cycle pulse when the last bit period of a frame completes.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, PRE (preamble, macro-dependent), DATA and GAP.
REQ-015 data_ready SHALL equal (state==IDLE) and not reset; the block SHALL accept a frame on a cycle where data_valid and data_ready are both high.
REQ-016 On acceptance, the block SHALL latch data_in into a shift register; data_in changes after acceptance SHALL have no effect.
REQ-017 The cycle after acceptance, the FSM SHALL enter PRE (macro defined) or DATA, with tone_en=1 and bit_strobe=1 registered on that same cycle.
REQ-018 In DATA, bits SHALL be sent LSB first, and tone_sel SHALL equal the current bit for exactly NB cycles per bit.
REQ-019 A cycle counter SHALL count 0..NB-1 and wrap to 0; on each wrap the bit index SHALL advance and bit_strobe SHALL pulse in the first cycle of the next bit.
REQ-020 After NB*LDATA DATA cycles, frame_done SHALL pulse for 1 cycle, coincident with the first GAP cycle (or the first IDLE cycle if GAP_BITS=0).
REQ-021 In GAP, tone_en SHALL be 0, tone_sel SHALL be 0 and bit_strobe SHALL be 0, for exactly GAP_BITS*NB cycles; the FSM SHALL then return to IDLE.
REQ-022 In IDLE, tone_en, tone_sel, bit_strobe and busy SHALL all be 0.
REQ-023 data_valid asserted outside IDLE SHALL be ignored and not queued; the next frame starts no earlier than the cycle after IDLE is re-entered, giving a minimum inter-frame spacing of one idle cycle.
REQ-024 Counters SHALL be sized as $clog2 of their terminal value plus 1 bit; they SHALL NOT overflow for any legal parameter value.
REQ-025 All outputs other than data_ready SHALL be registered.

Reset
REQ-026 While reset=1 at a clock edge, the state SHALL go to IDLE and all counters SHALL clear to 0; tone_en, tone_sel, bit_strobe, frame_done and busy SHALL be 0, and data_ready SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame without a frame_done pulse; the first cycle after reset is released SHALL be IDLE with data_ready=1.
REQ-028 Reset SHALL take priority over a simultaneous data_valid/data_ready acceptance.

Configuration
REQ-029 The macro BFSK_PREAMBLE_EN SHALL control the preamble, as follows.
REQ-030 With BFSK_PREAMBLE_EN defined, each frame SHALL begin with a PRE state of 8 bit periods carrying the fixed pattern 8'hAA, LSB first (0,1,0,1,...), with NB cycles per bit and a bit_strobe pulse per bit; DATA SHALL follow immediately.
REQ-031 With BFSK_PREAMBLE_EN undefined, the PRE state and its logic SHALL be absent, and acceptance SHALL lead directly to DATA.

Verification (NB=4, LDATA=8, GAP_BITS=2 unless stated)
REQ-032 Macro off: data_in=8'hAA accepted at cycle T -> from T+1, tone_sel runs 0,1,0,1,0,1,0,1, with each value held 4 cycles; tone_en=1 for 32 cycles; 8 bit_strobe pulses; frame_done at T+33; tone_en=0 for 8 cycles; data_ready=1 at T+41.
REQ-033 Macro on: data_in=8'hFF -> 32 cycles of preamble 0,1,0,1,... then tone_sel=1 for 32 cycles; 16 bit_strobe pulses; frame_done at T+65.
REQ-034 data_valid held high continuously with 8'h01 then 8'h80 -> the second frame is accepted only in IDLE after the first frame's GAP; the first frame's data is unaffected by data_in changes during transmission.
REQ-035 Reset pulsed at the 10th DATA cycle -> next cycle: tone_en=0, busy=0, no frame_done pulse, data_ready=1.
REQ-036 GAP_BITS=0, data_in=8'h0F -> frame_done coincides with the first IDLE cycle; a new frame can be accepted that cycle and starts the cycle after.
